// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: request/response bundle between the E-stage issue
// controller and the multiply/divide unit (XALU).
//   master (controller): drives Start, XALUOp, RD1, RD2; receives XBusy, XHI, XLO
//   slave  (XALU)      : receives the request, drives Busy and HI/LO
interface md_issue_ctrl_if;
  logic        Start;
  logic [2:0]  XALUOp;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        XBusy;
  logic [31:0] XHI;
  logic [31:0] XLO;

  modport master (
    output Start, XALUOp, RD1, RD2,
    input  XBusy, XHI, XLO
  );

  modport slave (
    input  Start, XALUOp, RD1, RD2,
    output XBusy, XHI, XLO
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue and interlock controller for the XALU.
// Issues multiply/divide/mthi/mtlo to the XALU, shadows its busy period with a
// countdown, stalls D-stage multiply/divide-class instructions while an
// operation is outstanding, registers mfhi/mflo results into M, and raises a
// sticky Mismatch when the countdown and XALU Busy disagree.
// Ports:
//   Clock, Reset (async, active-low)
//   D_MD                 D-stage instruction is multiply/divide class
//   E_Valid, E_IsMD,
//   E_MDOp, E_RS, E_RT   E-stage instruction and forwarded operands
//   xalu (master)        Start/XALUOp/RD1/RD2 out, XBusy/XHI/XLO in
//   Stall                freeze F/D, bubble E
//   M_MDOut, M_MDValid   registered mfhi/mflo result
//   Mismatch             sticky shadow/Busy disagreement
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              D_MD,
  input  logic              E_Valid,
  input  logic              E_IsMD,
  input  logic [2:0]        E_MDOp,
  input  logic [31:0]       E_RS,
  input  logic [31:0]       E_RT,
  md_issue_ctrl_if.master   xalu,
  output logic              Stall,
  output logic [31:0]       M_MDOut,
  output logic              M_MDValid,
  output logic              Mismatch
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  logic          start;
  logic          cnt_nz;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   mdout_q, mdout_d;
  logic          mdvld_q, mdvld_d;
  logic          mism_q, mism_d;

  // E stage: XALU request (ops 0..5 start the unit; mfhi/mflo do not)
  assign start       = E_Valid & E_IsMD & (E_MDOp <= 3'd5);
  assign cnt_nz      = (cnt_q != '0);
  assign xalu.Start  = start;
  assign xalu.XALUOp = E_MDOp;
  assign xalu.RD1    = E_RS;
  assign xalu.RD2    = E_RT;

  // mthi/mtlo hold Stall for their own issue cycle only, so a following mf
  // instruction reads the freshly written HI/LO.
  assign Stall = D_MD & (start | xalu.XBusy | cnt_nz);

  always_comb begin
    cnt_d = cnt_q;
    if (start && !E_MDOp[2]) begin
      cnt_d = E_MDOp[1] ? DIV_LD : MULT_LD;
    end else if (cnt_nz) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // busy_q tracks "Cnt != 0" for the cycle it will be compared in, which is
  // exactly the cycle the XALU should be holding Busy.
  assign busy_d = (cnt_d != '0);

  // An issue while a countdown is still running is also treated as a
  // disagreement with the XALU.
  assign mism_d = mism_q | (xalu.XBusy != busy_q) | (start & cnt_nz);

  always_comb begin
    mdout_d = mdout_q;
    mdvld_d = 1'b0;
    if (E_Valid && E_IsMD && (E_MDOp[2:1] == 2'b11)) begin
      mdout_d = E_MDOp[0] ? xalu.XLO : xalu.XHI;
      mdvld_d = 1'b1;
    end
  end

  // E -> M boundary
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      mdout_q <= '0;
      mdvld_q <= 1'b0;
      mism_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mdout_q <= mdout_d;
      mdvld_q <= mdvld_d;
      mism_q  <= mism_d;
    end
  end

  assign M_MDOut   = mdout_q;
  assign M_MDValid = mdvld_q;
  assign Mismatch  = mism_q;

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

E-stage issue and interlock controller placed directly upstream of the multiply/divide unit (XALU). It turns the E-stage instruction into the XALU `Start`/`XALUOp`/operand request and tracks the multi-cycle operation with a shadow countdown. It stalls any D-stage multiply/divide-class instruction while an operation is outstanding. It also registers `mfhi`/`mflo` results into the M stage and flags any disagreement between its countdown and XALU `Busy`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: XALU busy cycles for mult/multu. Legal range 1..255.
- `DIV_CYCLES`, default 10: XALU busy cycles for div/divu. Legal range 1..255, and must be >= `MULT_CYCLES`.

Ports:
- `Clock`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-low.
- `D_MD`  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- `E_Valid`  in  1  E stage holds a real instruction (0 = bubble).
- `E_IsMD`  in  1  E-stage instruction is multiply/divide class.
- `E_MDOp`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- `E_RS`, `E_RT`  in  32  forwarded rs/rt operands.
- `XBusy`  in  1  XALU `Busy`.
- `XHI`, `XLO`  in  32  XALU `HI`/`LO`.
- `Start`  out  1  to XALU.
- `XALUOp`  out  3  to XALU.
- `RD1`, `RD2`  out  32  to XALU.
- `Stall`  out  1  freeze F/D and insert an E bubble.
- `M_MDOut`  out  32  registered mfhi/mflo result.
- `M_MDValid`  out  1  `M_MDOut` is valid this cycle.
- `Mismatch`  out  1  sticky error: shadow countdown disagrees with `XBusy`.

## Operation
XALU issue (combinational):
- `Start = E_Valid & E_IsMD & (E_MDOp <= 5)`.
- `XALUOp = E_MDOp`.
- `RD1 = E_RS`, `RD2 = E_RT`. These are driven regardless of `Start`.
- mthi/mtlo assert `Start` for one cycle. XALU writes HI/LO at that edge.

Shadow counter `Cnt`, width `$clog2(DIV_CYCLES+1)`, updated at each rising edge:
- `Start` with op 0/1: load `MULT_CYCLES`.
- `Start` with op 2/3: load `DIV_CYCLES`.
- `Start` with op 4/5: no load; normal decrement applies.
- Otherwise, if `Cnt != 0`: decrement.
- `Start` arriving while `Cnt != 0` is illegal. It still reloads `Cnt` and sets `Mismatch`.

Interlock:
- `Stall = D_MD & (Start | XBusy | (Cnt != 0))`.
- A D-stage mfhi/mflo/mthi/mtlo also waits behind mthi/mtlo or an outstanding mult/div.
- The pipeline drops the stalled D instruction's E copy (`E_Valid = 0`), so each E instruction issues exactly once.

Result capture, at each edge:
- `E_Valid & E_IsMD & op 6`: `M_MDOut <= XHI`, `M_MDValid <= 1`.
- `E_Valid & E_IsMD & op 7`: `M_MDOut <= XLO`, `M_MDValid <= 1`.
- Otherwise: `M_MDValid <= 0` and `M_MDOut` holds its value.

Consistency check:
- A registered flag records whether `Cnt != 0`.
- `Mismatch` is set at any edge where `XBusy` differs from that flag.
- `Mismatch` is cleared only by reset.

## Timing
- Reset asserted (low) forces immediately: `Cnt = 0`, `M_MDOut = 0`, `M_MDValid = 0`, `Mismatch = 0`.
- While in reset, `Stall`, `Start`, `XALUOp`, `RD1`, `RD2` are combinational from the inputs and `Cnt = 0`.
- Reset mid-operation abandons the countdown. XALU is reset by the same `Reset`.
- XALU contract: samples `Start` at edge T. `Busy` is high for cycles T+1..T+N (N = `MULT_CYCLES` or `DIV_CYCLES`). HI/LO are final when `Busy` falls.
- Stall window for a D-stage MD instruction behind a mult: issue cycle plus N busy cycles, i.e. 1+N cycles (6 for mult, 11 for div).
- mthi/mtlo followed immediately by mfhi/mflo: exactly 1 stall cycle. The mf instruction reads the updated value in E.
- `M_MDOut` latency: one edge after the mfhi/mflo is in E.

## Test plan
- mult: `E_Valid=1`, `E_MDOp=0`, `RS=-7`, `RT=13`, `D_MD=1` → `Start=1`, `RD1=FFFFFFF9`; `Stall` high 6 cycles; subsequent mfhi/mflo give `M_MDOut=FFFFFFFF` / `FFFFFFA5`.
- div: `RS=8`, `RT=-3`, op 2 → `Cnt` loads 10; `Stall` high 11 cycles; mflo→`FFFFFFFE`, mfhi→`00000002`; `Mismatch=0`.
- mthi `RS=100` then mfhi back-to-back → 1 stall cycle; `M_MDOut=00000064`, `M_MDValid=1` for one cycle.
- Bubble: `E_Valid=0`, `E_MDOp=0` → `Start=0`, `Cnt` stays 0, `Stall=0` even with `D_MD=1`.
- Reset low at cycle 3 of a div → `Cnt=0`, `Stall=0` (`XBusy=0`), `M_MDValid=0` immediately; a new mult issues normally after release.
- Fault injection: after a mult issue, hold `XBusy=0` → `Mismatch=1` after the next edge; it stays high through later clean operations until reset.
